// File: rtl/stack_unit.sv
// Operand stack for the multicycle stack CPU: push/pop/peek/exchange on a
// DEPTH x WIDTH array with a registered output and sticky error flags.
module stack_unit #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             tos,
  input  logic             MtoS,
  input  logic [WIDTH-1:0] mem_data,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             clr_err,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] top;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    push_idx;
  logic             is_empty, is_full;
  logic             set_ovf, set_unf;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));
  assign din      = MtoS ? mem_data : alu_res;
  // Indices are only used when the matching empty/full guard allows it,
  // so the truncation at count==0 or count==DEPTH is harmless.
  assign top_idx  = AW'(count_q - CW'(1));
  assign push_idx = AW'(count_q);
  assign top      = mem_q[top_idx];

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    count_d = count_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    we      = 1'b0;
    waddr   = push_idx;

    if (push && pop) begin
      if (is_empty) begin
        set_unf = 1'b1;
      end else begin
        dout_d  = top;
        we      = 1'b1;
        waddr   = top_idx;
        valid_d = 1'b1;
      end
    end else if (pop) begin
      if (is_empty) begin
        set_unf = 1'b1;
      end else begin
        dout_d  = top;
        count_d = count_q - CW'(1);
        valid_d = 1'b1;
      end
    end else if (push && tos) begin
      if (is_empty) begin
        we      = 1'b1;
        count_d = count_q + CW'(1);
        set_unf = 1'b1;
      end else if (is_full) begin
        dout_d  = top;
        valid_d = 1'b1;
        set_ovf = 1'b1;
      end else begin
        dout_d  = top;
        we      = 1'b1;
        count_d = count_q + CW'(1);
        valid_d = 1'b1;
      end
    end else if (push) begin
      if (is_full) begin
        set_ovf = 1'b1;
      end else begin
        we      = 1'b1;
        count_d = count_q + CW'(1);
      end
    end else if (tos) begin
      if (is_empty) begin
        set_unf = 1'b1;
      end else begin
        dout_d  = top;
        valid_d = 1'b1;
      end
    end

    // A new error on the same edge as clr_err keeps the flag set.
    ovf_d = set_ovf | (ovf_q & ~clr_err);
    unf_d = set_unf | (unf_q & ~clr_err);
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      count_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; only count decides validity.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= din;
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign count      = count_q;
  assign empty      = is_empty;
  assign full       = is_full;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;

endmodule

// File: tb/tb_stack_unit.sv
// Self-checking bench for stack_unit: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_stack_unit;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             push = 1'b0, pop = 1'b0, tos = 1'b0, MtoS = 1'b0, clr_err = 1'b0;
  logic [WIDTH-1:0] mem_data = '0, alu_res = '0;
  logic [WIDTH-1:0] dout;
  logic             dout_valid, empty, full, overflow, underflow;
  logic [CW-1:0]    count;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_dout;
  logic             m_valid, m_ovf, m_unf;

  stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .tos(tos), .MtoS(MtoS),
    .mem_data(mem_data), .alu_res(alu_res), .clr_err(clr_err),
    .dout(dout), .dout_valid(dout_valid), .empty(empty), .full(full),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    m_dout = '0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  // Apply one cycle of stimulus, then advance the model by the same operation.
  task automatic cycle(input logic pu, input logic po, input logic to, input logic ms,
                       input logic [WIDTH-1:0] md, input logic [WIDTH-1:0] ar,
                       input logic ce);
    logic [WIDTH-1:0] d;
    logic so, su;
    push = pu; pop = po; tos = to; MtoS = ms; mem_data = md; alu_res = ar; clr_err = ce;
    @(posedge clk);
    #1;
    d = ms ? md : ar;
    so = 1'b0; su = 1'b0; m_valid = 1'b0;
    if (pu && po) begin
      if (q.size() == 0) su = 1'b1;
      else begin m_dout = q[$]; q[$] = d; m_valid = 1'b1; end
    end else if (po) begin
      if (q.size() == 0) su = 1'b1;
      else begin m_dout = q.pop_back(); m_valid = 1'b1; end
    end else if (pu && to) begin
      if (q.size() == 0) begin q.push_back(d); su = 1'b1; end
      else if (q.size() == DEPTH) begin m_dout = q[$]; m_valid = 1'b1; so = 1'b1; end
      else begin m_dout = q[$]; q.push_back(d); m_valid = 1'b1; end
    end else if (pu) begin
      if (q.size() == DEPTH) so = 1'b1;
      else q.push_back(d);
    end else if (to) begin
      if (q.size() == 0) su = 1'b1;
      else begin m_dout = q[$]; m_valid = 1'b1; end
    end
    m_ovf = so | (m_ovf & ~ce);
    m_unf = su | (m_unf & ~ce);
    push = 1'b0; pop = 1'b0; tos = 1'b0; clr_err = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({count, empty, full, dout, dout_valid, overflow, underflow} !==
        {CW'(0), 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      $display("FAIL reset_state: count=%0d empty=%b full=%b dout=%h valid=%b ovf=%b unf=%b expected 0/1/0/00/0/0/0",
               count, empty, full, dout, dout_valid, overflow, underflow);
      bad++;
    end
  endtask

  task automatic test_push_seq();
    cycle(1, 0, 0, 0, 8'h00, 8'h11, 0);
    total++;
    if (dout_valid !== 1'b0) begin $display("FAIL push1_valid: got %b expected 0", dout_valid); bad++; end
    cycle(1, 0, 0, 0, 8'h00, 8'h22, 0);
    total++;
    if ({count, empty, dout, dout_valid} !== {CW'(2), 1'b0, 8'h00, 1'b0}) begin
      $display("FAIL push_seq: count=%0d empty=%b dout=%h valid=%b expected 2/0/00/0",
               count, empty, dout, dout_valid);
      bad++;
    end
  endtask

  task automatic test_mtos_pop();
    cycle(1, 0, 0, 1, 8'hA5, 8'h3C, 0);
    cycle(0, 1, 0, 0, 8'h00, 8'h00, 0);
    total++;
    if ({dout, dout_valid} !== {8'hA5, 1'b1}) begin
      $display("FAIL pop_mtos: dout=%h valid=%b expected a5/1", dout, dout_valid); bad++;
    end
    cycle(0, 1, 0, 0, 8'h00, 8'h00, 0);
    total++;
    if ({dout, dout_valid, count} !== {8'h22, 1'b1, CW'(1)}) begin
      $display("FAIL pop_order: dout=%h valid=%b count=%0d expected 22/1/1", dout, dout_valid, count); bad++;
    end
    @(posedge clk); #1;
    total++;
    if (dout_valid !== 1'b0 || dout !== 8'h22) begin
      $display("FAIL valid_pulse: valid=%b dout=%h expected 0/22", dout_valid, dout); bad++;
    end
  endtask

  task automatic test_tos();
    for (int i = 0; i < 2; i++) begin
      cycle(0, 0, 1, 0, 8'h00, 8'h00, 0);
      total++;
      if ({dout, dout_valid, count} !== {8'h11, 1'b1, CW'(1)}) begin
        $display("FAIL tos_peek%0d: dout=%h valid=%b count=%0d expected 11/1/1", i, dout, dout_valid, count);
        bad++;
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= DEPTH; i++) cycle(1, 0, 0, 0, 8'h00, 8'(i), 0);
    cycle(1, 0, 0, 0, 8'h00, 8'h55, 0);
    total++;
    if ({count, full, overflow} !== {CW'(4), 1'b1, 1'b1}) begin
      $display("FAIL overflow: count=%0d full=%b ovf=%b expected 4/1/1", count, full, overflow); bad++;
    end
    cycle(0, 1, 0, 0, 8'h00, 8'h00, 0);
    total++;
    if (dout !== 8'h04) begin $display("FAIL ovf_no_write: dout=%h expected 04", dout); bad++; end
    cycle(0, 0, 0, 0, 8'h00, 8'h00, 1);
    total++;
    if (overflow !== 1'b0) begin $display("FAIL clr_err: ovf=%b expected 0", overflow); bad++; end
    // push&tos while full: peek succeeds, push rejected
    cycle(1, 0, 0, 0, 8'h00, 8'h66, 0);
    cycle(1, 0, 1, 0, 8'h00, 8'h77, 1);
    total++;
    if ({dout, dout_valid, count, overflow} !== {8'h66, 1'b1, CW'(4), 1'b1}) begin
      $display("FAIL push_tos_full: dout=%h valid=%b count=%0d ovf=%b expected 66/1/4/1 (set beats clr)",
               dout, dout_valid, count, overflow);
      bad++;
    end
  endtask

  task automatic test_underflow_exchange();
    do_reset();
    cycle(0, 1, 0, 0, 8'h00, 8'h00, 0);
    total++;
    if ({underflow, dout, count, dout_valid} !== {1'b1, 8'h00, CW'(0), 1'b0}) begin
      $display("FAIL underflow: unf=%b dout=%h count=%0d valid=%b expected 1/00/0/0",
               underflow, dout, count, dout_valid);
      bad++;
    end
    cycle(1, 0, 0, 0, 8'h00, 8'h10, 0);
    cycle(1, 1, 0, 0, 8'h00, 8'h20, 0);
    total++;
    if ({dout, dout_valid, count} !== {8'h10, 1'b1, CW'(1)}) begin
      $display("FAIL exchange: dout=%h valid=%b count=%0d expected 10/1/1", dout, dout_valid, count); bad++;
    end
    cycle(0, 0, 1, 0, 8'h00, 8'h00, 0);
    total++;
    if (dout !== 8'h20) begin $display("FAIL exchange_tos: dout=%h expected 20", dout); bad++; end
    // push&tos on empty: push happens, underflow flagged, no valid
    do_reset();
    cycle(1, 0, 1, 1, 8'h9C, 8'h00, 0);
    total++;
    if ({count, underflow, dout_valid} !== {CW'(1), 1'b1, 1'b0}) begin
      $display("FAIL push_tos_empty: count=%0d unf=%b valid=%b expected 1/1/0", count, underflow, dout_valid);
      bad++;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    cycle(0, 1, 0, 0, 8'h00, 8'h00, 0);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 8'h00, 8'(8'hB0 + i), 0);
    cycle(1, 0, 0, 0, 8'h00, 8'hEE, 0);
    cycle(0, 1, 0, 0, 8'h00, 8'h00, 0);
    pop = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({count, dout, overflow, underflow, empty} !== {CW'(0), 8'h00, 1'b0, 1'b0, 1'b1}) begin
      $display("FAIL async_reset: count=%0d dout=%h ovf=%b unf=%b empty=%b expected 0/00/0/0/1",
               count, dout, overflow, underflow, empty);
      bad++;
    end
    pop = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    logic [CW+WIDTH+5:0] exp_v, got_v;
    int errs = 0;
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 30,
            1'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 99) < 8);
      exp_v = {CW'(q.size()), q.size() == 0, q.size() == DEPTH, m_dout, m_valid, m_ovf, m_unf};
      got_v = {count, empty, full, dout, dout_valid, overflow, underflow};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        if (errs++ < 10)
          $display("FAIL random[%0d]: count/empty/full/dout/valid/ovf/unf got %h expected %h", i, got_v, exp_v);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_push_seq();
    test_mtos_pop();
    test_tos();
    test_overflow();
    test_underflow_exchange();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
